// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FPU definitions. This package provides the FP32 field
//               widths, the exponent bias, the packed FP32 struct and the
//               int-to-float exponent base.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  // When a 32-bit integer is normalised with its leading one at bit 31, the
  // value is 2^31. The biased exponent of 2^31 is BIAS + 31 = 158. Every
  // leading zero in front of the one lowers the exponent by one.
  localparam int CVT_EXP_BASE = BIAS + 31;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/lzc32.sv
`default_nettype none
// ============================================================================
// Module      : lzc32
// Description : Combinational 32-bit leading-zero counter.
//               The output counts the zeros above the most significant set
//               bit. An all-zero input gives 32.
// Ports       : data  [31:0] in  - value to scan
//               count [5:0]  out - leading-zero count, 0..32
// Revision    : 1.0 - initial release
// ============================================================================
module lzc32 (
  input  logic [31:0] data,
  output logic [5:0]  count
);

  // The scan runs from the LSB upward. The last set bit it finds is the
  // most significant one, so that bit sets the final count.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (data[i]) begin
        count = 6'(31 - i);
      end
    end
  end

endmodule : lzc32
`default_nettype wire

// File: rtl/fcvt_s_w.sv
`default_nettype none
// ============================================================================
// Module      : fcvt_s_w
// Description : Two-stage pipelined converter from integer to IEEE-754
//               single precision. It implements fcvt.s.w (signed) and
//               fcvt.s.wu (unsigned).
//               Stage 1 computes the sign, the magnitude and the leading-zero
//               count. Stage 2 normalises, rounds and packs the result.
//               Both sides use a ready/valid handshake, and the converter
//               accepts one operand per cycle.
// Ports       : clk, rstn (async, active low), flush (sync drop-all)
//               in_valid/in_ready/in_data/in_unsigned/in_tag  - operand side
//               out_valid/out_ready/out_data/out_tag          - result side
// Parameters  : TAG_W  - width of the opaque destination tag
//               RNE_EN - 1: round to nearest even, 0: truncate toward zero
// Revision    : 1.0 - initial release
// ============================================================================
module fcvt_s_w
  import fpu_pkg::*;
#(
  parameter int TAG_W  = 5,
  parameter int RNE_EN = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam bit         c_rne      = (RNE_EN != 0);
  localparam logic [7:0] c_exp_base = 8'(CVT_EXP_BASE);

  // --------------------------------------------------------------------------
  // Handshake and stage enables
  // --------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s1_en;
  logic w_s2_en;
  logic w_accept;

  assign w_s2_en  = ~r_s2_valid | out_ready;
  assign w_s1_en  = ~r_s1_valid | w_s2_en;
  // During a flush cycle the pipeline is cleared. An operand offered in that
  // cycle must not slip in, so in_ready is forced low.
  assign in_ready = w_s1_en & ~flush;
  assign w_accept = in_valid & in_ready;

  // --------------------------------------------------------------------------
  // Stage 1: sign, magnitude, leading-zero count
  // --------------------------------------------------------------------------
  logic        w_sign;
  logic [31:0] w_mag;
  logic [5:0]  w_lz;

  assign w_sign = ~in_unsigned & in_data[31];
  // Negating 0x80000000 gives 0x80000000 again. That value is the correct
  // magnitude 2^31 when it is read as unsigned.
  assign w_mag  = w_sign ? (~in_data + 32'd1) : in_data;

  lzc32 u_lzc (
    .data  (w_mag),
    .count (w_lz)
  );

  logic             r_s1_sign;
  logic [31:0]      r_s1_mag;
  logic [5:0]       r_s1_lz;
  logic             r_s1_zero;
  logic [TAG_W-1:0] r_s1_tag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_sign <= 1'b0;
      r_s1_mag  <= '0;
      r_s1_lz   <= '0;
      r_s1_zero <= 1'b0;
      r_s1_tag  <= '0;
    end else if (w_accept) begin
      r_s1_sign <= w_sign;
      r_s1_mag  <= w_mag;
      r_s1_lz   <= w_lz;
      r_s1_zero <= (w_lz == 6'd32);
      r_s1_tag  <= in_tag;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: normalise, round, pack
  // --------------------------------------------------------------------------
  // After the shift, the leading one sits at bit 31. That bit is the hidden
  // bit, so only bits 30:0 are needed.
  logic [30:0] w_norm;
  logic [7:0]  w_exp;
  logic [22:0] w_frac;
  logic        w_guard;
  logic        w_sticky;
  logic        w_round_up;
  logic [23:0] w_frac_sum;
  logic [7:0]  w_exp_rnd;
  fp32_t       w_result;

  assign w_norm     = 31'(r_s1_mag << r_s1_lz);
  assign w_exp      = c_exp_base - {2'b00, r_s1_lz};
  assign w_frac     = w_norm[30:8];
  assign w_guard    = w_norm[7];
  assign w_sticky   = |w_norm[6:0];
  assign w_round_up = c_rne & w_guard & (w_sticky | w_frac[0]);

  // A carry out of the fraction leaves the low 23 bits at zero, and the
  // exponent increases by one. The largest possible value is 2^32, which
  // has exponent 159, so the result cannot overflow to infinity.
  assign w_frac_sum = {1'b0, w_frac} + {23'd0, w_round_up};
  assign w_exp_rnd  = w_exp + {7'd0, w_frac_sum[23]};

  always_comb begin
    w_result = '0;
    if (!r_s1_zero) begin
      w_result.sign = r_s1_sign;
      w_result.exp  = w_exp_rnd;
      w_result.frac = w_frac_sum[22:0];
    end
  end

  logic [31:0]      r_out_data;
  logic [TAG_W-1:0] r_out_tag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_data <= '0;
      r_out_tag  <= '0;
    end else if (!flush && w_s2_en && r_s1_valid) begin
      r_out_data <= w_result;
      r_out_tag  <= r_s1_tag;
    end
  end

  // --------------------------------------------------------------------------
  // Stage valids
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= w_accept;
      end
      if (w_s2_en) begin
        r_s2_valid <= r_s1_valid;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;

endmodule : fcvt_s_w
`default_nettype wire
